data_access_unit: RTL and testbench
===================================

# data_access_unit

Memory-stage sequencer that serialises scalar and 128-bit vector loads/stores onto the 32-bit data memory port and raises `BusyDA` while an access is in flight. It sits in the M stage between the EX/MEM and MEM/WB pipeline registers. It produces the `BusyDA` the hazard unit uses to stall every stage. It delivers `ReadDataM` / `ReadDataVM` to the write-back path.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, memory word width; fixed at 32
- `VEC_W`, 128, vector register width; `BEATS = VEC_W/DATA_W = 4`
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `MemReadM`  in  1  load in M stage
- `MemWriteM`  in  1  store in M stage
- `VecM`  in  1  1 = vector access (4 beats), 0 = scalar (1 beat)
- `ALUResultM`  in  ADDR_W  base byte address
- `WriteDataM`  in  32  scalar store data
- `WriteDataVM`  in  128  vector store data
- `BusyDA`  out  1  access in progress; hazard unit stalls all stages
- `ReadDataM`  out  32  scalar load result (= buffer[31:0])
- `ReadDataVM`  out  128  vector load result
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  ADDR_W  word-aligned beat address
- `mem_wdata`  out  32  write beat data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid; one cycle after a granted read, in order
- `mem_rdata`  in  32  read beat data

## Operation
- `access = MemReadM | MemWriteM`. `beats = VecM ? 4 : 1`. `MemReadM & MemWriteM` together is illegal and is treated as a read.
- Base address: low 4 bits are forced to 0 for vector accesses and low 2 bits for scalar. Beat k uses address `base + 4k`, data slice `[32k+31:32k]`, little-endian beat order.
- FSM has three states:
  - IDLE → BUSY when `access` is set; beat 0 is issued in this same cycle.
  - BUSY → DONE once every beat is granted and, for reads, every `mem_rvalid` has been received.
  - DONE → IDLE unconditionally. In DONE the inputs are ignored, because the completed instruction is still in M.
- Counters:
  - `issue_cnt` (0..4) increments on `mem_req & mem_gnt`.
  - `rsp_cnt` (0..4) increments on `mem_rvalid` while in BUSY; each response is written into buffer slot `rsp_cnt`.
- `mem_req = (IDLE & access) | (BUSY & issue_cnt < beats)`. `mem_we`, `mem_addr` and `mem_wdata` are combinational from `issue_cnt` and the held M inputs.
- `BusyDA = (IDLE & access) | BUSY`. It is 0 in DONE so the pipeline advances exactly once.
- Read buffer is 128 bits, registered, and holds its value until the next read overwrites it. A scalar read updates only slot 0. `ReadDataVM`/`ReadDataM` are valid in the DONE cycle.
- A `mem_rvalid` arriving with no outstanding read is ignored.
- M-stage inputs are stable while `BusyDA` is high, because the hazard unit holds the M stage.

## Timing
- Reset values:
  - state = IDLE; `issue_cnt` = `rsp_cnt` = 0; buffer = 0.
  - `mem_req` = 0 (requires `access` = 0 during reset); `BusyDA` follows the combinational rule.
- Reset asserted mid-access aborts immediately. Outstanding responses are dropped, and a late `rvalid` after reset is ignored.
- Latencies with `mem_gnt` = 1, cycle 0 = instruction enters M:
  - vector read: beats issued cycles 0–3, responses 1–4, DONE at cycle 5, `BusyDA` high cycles 0–4;
  - vector write: DONE at cycle 4, busy cycles 0–3;
  - scalar read: DONE at cycle 2, busy cycles 0–1;
  - scalar write: DONE at cycle 1, busy cycle 0 only.
- While `mem_gnt` = 0: `mem_req`, `mem_addr` and `mem_wdata` are held, `issue_cnt` is frozen, and `BusyDA` stays high.
- Back-to-back accesses: the instruction after DONE is seen in IDLE on the next cycle and is issued with no bubble beyond the DONE cycle.

## Structure
- Shared `mem_access_pkg`:
  - `da_state_t` enum {IDLE, BUSY, DONE};
  - `BEATS_VEC = 4`, `BEAT_BYTES = 4`.
- Single module; no sub-module needed. The read buffer is an inline register array.

## Test plan
- Vector load at base 0x0000_0103, memory words 0x11111111..0x44444444, `gnt` = 1:
  - addresses 0x100, 0x104, 0x108, 0x10C;
  - `ReadDataVM` = 0x44444444_33333333_22222222_11111111 at cycle 5;
  - `BusyDA` high for exactly 5 cycles.
- Vector store with `WriteDataVM` = 0xDDDD_CCCC_BBBB_AAAA_... and `gnt` low for cycles 1–2: four write beats in order, data held during the wait, DONE at cycle 6.
- Scalar load at 0x20 followed immediately by scalar store at 0x24:
  - load: `BusyDA` for 2 cycles, DONE;
  - store: issued the next cycle, `BusyDA` for 1 cycle.
- `rst_n` pulsed low during beat 2 of a vector read: `mem_req` = 0 and state = IDLE immediately; stray `rvalid` ignored; buffer = 0.
- Spurious `mem_rvalid` while in IDLE with no access: buffer unchanged, `BusyDA` = 0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the M-stage data access sequencer.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } da_state_t;

    localparam int BEATS_VEC  = 4;
    localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/data_access_unit.sv
// Serialises scalar and 128-bit vector loads/stores onto the 32-bit data memory
// port and stalls the pipeline through BusyDA while an access is in flight.
//
// state | meaning
// IDLE  | waiting for a load/store in M; beat 0 goes out in the same cycle
// BUSY  | issuing beats and/or collecting read responses
// DONE  | access complete, results valid; pipeline advances once
module data_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int VEC_W  = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MemReadM,
    input  logic                MemWriteM,
    input  logic                VecM,
    input  logic [ADDR_W-1:0]   ALUResultM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [VEC_W-1:0]    WriteDataVM,
    output logic                BusyDA,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic [VEC_W-1:0]    ReadDataVM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BEATS = VEC_W / DATA_W;

    da_state_t state, stateNext;
    logic [2:0] issueCnt, rspCnt, issueNext, rspNext, beats;
    logic [BEATS-1:0][DATA_W-1:0] readBuf;
    logic [BEATS-1:0][DATA_W-1:0] wrVec;
    logic [ADDR_W-1:0] baseAddr;
    logic access, isRead, grant, rspTake, allDone;

    assign access = MemReadM | MemWriteM;
    // A simultaneous read and write request is handled as a read.
    assign isRead = MemReadM;
    assign beats  = VecM ? 3'(BEATS_VEC) : 3'd1;
    assign wrVec  = WriteDataVM;

    assign baseAddr = VecM ? {ALUResultM[ADDR_W-1:4], 4'b0000}
                           : {ALUResultM[ADDR_W-1:2], 2'b00};

    assign mem_req   = ((state == IDLE) & access) | ((state == BUSY) & (issueCnt < beats));
    assign mem_we    = MemWriteM & ~MemReadM;
    assign mem_addr  = baseAddr + ADDR_W'({issueCnt, 2'b00});
    assign mem_wdata = VecM ? wrVec[issueCnt[1:0]] : WriteDataM;

    assign BusyDA = ((state == IDLE) & access) | (state == BUSY);

    assign grant = mem_req & mem_gnt;
    // Responses only count while a granted read is still outstanding.
    assign rspTake = (state == BUSY) & mem_rvalid & isRead & (rspCnt < issueCnt);

    assign issueNext = issueCnt + {2'b00, grant};
    assign rspNext   = rspCnt + {2'b00, rspTake};
    assign allDone   = (issueNext == beats) & (~isRead | (rspNext == beats));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (access) stateNext = allDone ? DONE : BUSY;
            BUSY:    if (allDone) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            issueCnt <= 3'd0;
            rspCnt   <= 3'd0;
        end else begin
            state <= stateNext;
            if (state == DONE) begin
                issueCnt <= 3'd0;
                rspCnt   <= 3'd0;
            end else begin
                issueCnt <= issueNext;
                rspCnt   <= rspNext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readBuf <= '0;
        end else if (rspTake) begin
            readBuf[rspCnt[1:0]] <= mem_rdata;
        end
    end

    assign ReadDataVM = readBuf;
    assign ReadDataM  = readBuf[0];

endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit: a memory responder, a beat/result
// monitor and a driver feeding directed and randomized loads/stores.
module tb_data_access_unit;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         MemReadM, MemWriteM, VecM;
    logic [31:0]  ALUResultM, WriteDataM;
    logic [127:0] WriteDataVM;
    logic         BusyDA;
    logic [31:0]  ReadDataM;
    logic [127:0] ReadDataVM;
    logic         mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    beat_t        beatQ[$];
    logic [127:0] resQ[$];
    bit           gntQ[$];
    logic [127:0] refBuf;
    logic [31:0]  memArr[256];
    int           checks = 0;
    int           failures = 0;
    int           stallCnt = 0;
    bit           randGnt = 0;
    bit           strayRv = 0;

    always #5 clk = ~clk;

    data_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .VecM(VecM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteDataVM(WriteDataVM),
        .BusyDA(BusyDA), .ReadDataM(ReadDataM), .ReadDataVM(ReadDataVM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: grants per gntQ or randomly, returns read data one cycle later.
    initial begin
        logic        pv;
        logic [31:0] pd;
        pd = '0;
        mem_gnt = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            pv = 1'b0;
            if (rst_n === 1'b1 && mem_req === 1'b1) begin
                if (!mem_gnt) stallCnt++;
                else if (mem_we) memArr[mem_addr[9:2]] = mem_wdata;
                else begin
                    pv = 1'b1;
                    pd = memArr[mem_addr[9:2]];
                end
            end
            @(posedge clk);
            #2;
            mem_rvalid = pv | strayRv;
            mem_rdata  = strayRv ? $urandom : pd;
            strayRv    = 1'b0;
            if (gntQ.size() > 0) mem_gnt = gntQ.pop_front();
            else mem_gnt = randGnt ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: checks every presented beat and the result in the completion cycle.
    initial begin
        beat_t b;
        logic [127:0] r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (mem_req === 1'b1) begin
                    if (beatQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected actual addr=%h required=no request", mem_addr);
                    end else if (mem_gnt) begin
                        b = beatQ.pop_front();
                        check("beat_addr", mem_addr, b.addr);
                        check("beat_we", mem_we, b.we);
                        if (b.we) check("beat_wdata", mem_wdata, b.wdata);
                    end else begin
                        b = beatQ[0];
                        check("held_addr", mem_addr, b.addr);
                        if (b.we) check("held_wdata", mem_wdata, b.wdata);
                    end
                end
                if ((MemReadM | MemWriteM) && !BusyDA) begin
                    if (resQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected actual=done required=no completion");
                    end else begin
                        r = resQ.pop_front();
                        check("result_vec", ReadDataVM, r);
                        check("result_scalar", ReadDataM, r[31:0]);
                    end
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        MemReadM = 0;
        MemWriteM = 0;
        VecM = 0;
    endtask

    task automatic doAccess(input bit rd, input bit wr, input bit vec, input logic [31:0] addr,
                            input logic [127:0] wdv, input logic [31:0] wds, output int busy);
        logic [31:0]  base;
        logic [127:0] exp;
        int nb, expBusy;
        bit done;
        @(posedge clk);
        #1;
        MemReadM = rd;
        MemWriteM = wr;
        VecM = vec;
        ALUResultM = addr;
        WriteDataVM = wdv;
        WriteDataM = wds;
        stallCnt = 0;
        nb   = vec ? 4 : 1;
        base = vec ? (addr & 32'hFFFF_FFF0) : (addr & 32'hFFFF_FFFC);
        exp  = refBuf;
        for (int k = 0; k < nb; k++) begin
            beatQ.push_back('{base + 32'(4 * k), wr & ~rd, vec ? wdv[32*k +: 32] : wds});
            if (rd) exp[32*k +: 32] = memArr[8'((base + 32'(4 * k)) >> 2)];
        end
        refBuf = exp;
        resQ.push_back(exp);
        busy = 0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (BusyDA) busy++;
            else done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_timeout actual=busy %0d cycles required=completion", busy);
        end
        expBusy = nb + stallCnt + (rd ? 1 : 0);
        check("busy_cycles", busy, expBusy);
    endtask

    initial begin
        int busy;
        bit rd, wr;
        int op;
        rst_n = 0;
        MemReadM = 0; MemWriteM = 0; VecM = 0;
        ALUResultM = '0; WriteDataM = '0; WriteDataVM = '0;
        refBuf = '0;
        for (int i = 0; i < 256; i++) memArr[i] = $urandom | 32'h1;
        #1;
        check("reset_req", mem_req, 1'b0);
        check("reset_busy", BusyDA, 1'b0);
        check("reset_buf", ReadDataVM, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Vector load, unaligned base.
        memArr[64] = 32'h11111111; memArr[65] = 32'h22222222;
        memArr[66] = 32'h33333333; memArr[67] = 32'h44444444;
        doAccess(1, 0, 1, 32'h0000_0103, '0, '0, busy);
        check("vload_busy", busy, 5);
        check("vload_data", ReadDataVM, 128'h44444444_33333333_22222222_11111111);

        // Vector store with grant low in cycles 1-2.
        gntQ.push_back(1); gntQ.push_back(0); gntQ.push_back(0);
        doAccess(0, 1, 1, 32'h0000_0305,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0, busy);
        check("vstore_busy", busy, 6);

        // Scalar load then scalar store, back to back.
        doAccess(1, 0, 0, 32'h0000_0020, '0, '0, busy);
        check("sload_busy", busy, 2);
        check("sload_data", ReadDataM, memArr[8]);
        doAccess(0, 1, 0, 32'h0000_0024, '0, 32'hCAFE_F00D, busy);
        check("sstore_busy", busy, 1);
        idle();

        // Randomized mix with random grant stalls.
        randGnt = 1;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 6);
            rd = (op <= 2) || (op == 6);
            wr = (op >= 3);
            doAccess(rd, wr, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
                     {$urandom, $urandom, $urandom, $urandom}, $urandom, busy);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        randGnt = 0;
        repeat (3) @(negedge clk);

        // Spurious response while idle.
        strayRv = 1;
        repeat (3) @(negedge clk);
        check("spurious_buf", ReadDataVM, refBuf);
        check("spurious_busy", BusyDA, 1'b0);

        // Reset during beat 2 of a vector read.
        @(posedge clk);
        #1;
        MemReadM = 1; VecM = 1; ALUResultM = 32'h0000_0200;
        for (int k = 0; k < 4; k++) beatQ.push_back('{32'h200 + 32'(4 * k), 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #3;
        rst_n = 0;
        MemReadM = 0; VecM = 0;
        beatQ.delete();
        resQ.delete();
        refBuf = '0;
        #1;
        check("rst_mid_req", mem_req, 1'b0);
        check("rst_mid_busy", BusyDA, 1'b0);
        check("rst_mid_buf", ReadDataVM, 128'h0);
        @(negedge clk);
        rst_n = 1;
        strayRv = 1;
        repeat (3) @(negedge clk);
        check("late_rvalid_buf", ReadDataVM, 128'h0);
        check("late_rvalid_busy", BusyDA, 1'b0);
        check("late_rvalid_req", mem_req, 1'b0);

        check("beatq_drained", beatQ.size(), 0);
        check("resq_drained", resQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
